branch_resolve: RTL and testbench

- Consumer side of the branch comparator. Drives its signed/unsigned select from funct3 and takes back its less/equal flags.
- Decides whether a branch or jump is taken, then issues a registered PC redirect and a multi-cycle front-end flush.
- Sits between the decode/execute stage and the fetch PC mux in the RV32I core.

---
 rtl/branch_resolve_if.sv | 30 +++
 rtl/branch_resolve.sv | 124 ++++++++++++
 tb/tb_branch_resolve.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_if.sv
// Execute-stage <-> branch resolve bundle: instruction handshake, comparator
// mode/flags, redirect/flush outputs and the optional statistics counters.
interface branch_resolve_if #(
  parameter int CNT_W = 32
);
  logic             instr_vld_i;
  logic             ready_o;
  logic             is_br_i;
  logic             is_jal_i;
  logic             is_jalr_i;
  logic [2:0]       funct3_i;
  logic             br_less_i;
  logic             br_equal_i;
  logic             br_signed_o;
  logic             pc_sel_o;
  logic             flush_o;
  logic             illegal_o;
  logic [CNT_W-1:0] br_cnt_o;
  logic [CNT_W-1:0] taken_cnt_o;

  modport slave (
    input  instr_vld_i, is_br_i, is_jal_i, is_jalr_i, funct3_i, br_less_i, br_equal_i,
    output ready_o, br_signed_o, pc_sel_o, flush_o, illegal_o, br_cnt_o, taken_cnt_o
  );

  modport master (
    output instr_vld_i, is_br_i, is_jal_i, is_jalr_i, funct3_i, br_less_i, br_equal_i,
    input  ready_o, br_signed_o, pc_sel_o, flush_o, illegal_o, br_cnt_o, taken_cnt_o
  );
endinterface

// File: rtl/branch_resolve.sv
// Branch/jump resolution: taken decision, registered PC redirect and a
// FLUSH_CYCLES-long front-end flush. Define BR_STATS_EN for branch counters.
module branch_resolve #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  branch_resolve_if.slave  bus
);

  generate
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush_cycles
      $error("branch_resolve: FLUSH_CYCLES must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] FC = 4'(FLUSH_CYCLES);

  typedef enum logic {IDLE, FLUSH} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       pc_sel_q, illegal_q;
  logic       ready, flush;
  logic       accept, jump, is_cbr, legal, cond, taken;

  // Unsigned compare only for BLTU/BGEU (funct3 11x)
  assign bus.br_signed_o = ~(bus.funct3_i[2] & bus.funct3_i[1]);

  always_comb begin
    cond = 1'b0;
    unique case (bus.funct3_i)
      3'b000:  cond = bus.br_equal_i;
      3'b001:  cond = ~bus.br_equal_i;
      3'b100:  cond = bus.br_less_i;
      3'b101:  cond = ~bus.br_less_i;
      3'b110:  cond = bus.br_less_i;
      3'b111:  cond = ~bus.br_less_i;
      default: cond = 1'b0;
    endcase
  end

  // Jumps outrank branches, so a conditional branch only counts without a jump flag
  assign jump   = bus.is_jal_i | bus.is_jalr_i;
  assign is_cbr = bus.is_br_i & ~jump;
  assign legal  = (bus.funct3_i[2:1] != 2'b01);
  assign accept = bus.instr_vld_i & ready;
  assign taken  = jump | (is_cbr & legal & cond);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept && taken) begin
          state_d = FLUSH;
          cnt_d   = FC;
        end
      end
      FLUSH: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    flush = 1'b0;
    unique case (state_q)
      IDLE:    ready = ~rst_i;
      FLUSH:   flush = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_sel_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      pc_sel_q  <= accept & taken;
      illegal_q <= accept & is_cbr & ~legal;
    end
  end

  assign bus.ready_o   = ready;
  assign bus.flush_o   = flush;
  assign bus.pc_sel_o  = pc_sel_q;
  assign bus.illegal_o = illegal_q;

`ifdef BR_STATS_EN
  logic [CNT_W-1:0] br_cnt_q, taken_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
    end else if (accept && is_cbr && legal) begin
      br_cnt_q <= br_cnt_q + 1'b1;
      if (cond) taken_cnt_q <= taken_cnt_q + 1'b1;
    end
  end

  assign bus.br_cnt_o    = br_cnt_q;
  assign bus.taken_cnt_o = taken_cnt_q;
`else
  assign bus.br_cnt_o    = '0;
  assign bus.taken_cnt_o = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: decode, redirect/flush timing, illegal
// funct3, held instruction during flush, async reset and statistics.
module tb_branch_resolve;
  localparam int FC    = 2;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  branch_resolve_if #(.CNT_W(CNT_W)) bus ();
  branch_resolve_if #(.CNT_W(CNT_W)) bus3 ();

  branch_resolve #(.FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  // Second instance with a longer flush, fed the same instruction stream
  branch_resolve #(.FLUSH_CYCLES(3), .CNT_W(CNT_W)) dut3 (
    .clk_i(clk), .rst_i(rst), .bus(bus3)
  );

  assign bus3.instr_vld_i = bus.instr_vld_i;
  assign bus3.is_br_i     = bus.is_br_i;
  assign bus3.is_jal_i    = bus.is_jal_i;
  assign bus3.is_jalr_i   = bus.is_jalr_i;
  assign bus3.funct3_i    = bus.funct3_i;
  assign bus3.br_less_i   = bus.br_less_i;
  assign bus3.br_equal_i  = bus.br_equal_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic br, input logic jal, input logic jalr,
                       input logic [2:0] f3, input logic less, input logic eq);
    bus.instr_vld_i = vld;
    bus.is_br_i     = br;
    bus.is_jal_i    = jal;
    bus.is_jalr_i   = jalr;
    bus.funct3_i    = f3;
    bus.br_less_i   = less;
    bus.br_equal_i  = eq;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Called at the negedge right after the accepting edge
  task automatic expect_redirect(input string tag);
    for (int i = 0; i < FC; i++) begin
      chk({tag, ".pc_sel"}, 32'(bus.pc_sel_o), (i == 0) ? 32'd1 : 32'd0);
      chk({tag, ".flush"},  32'(bus.flush_o), 32'd1);
      chk({tag, ".ready"},  32'(bus.ready_o), 32'd0);
      tick();
    end
    chk({tag, ".flush_end"}, 32'(bus.flush_o), 32'd0);
    chk({tag, ".ready_end"}, 32'(bus.ready_o), 32'd1);
    chk({tag, ".pc_sel_end"}, 32'(bus.pc_sel_o), 32'd0);
  endtask

  task automatic expect_none(input string tag);
    chk({tag, ".pc_sel"}, 32'(bus.pc_sel_o), 32'd0);
    chk({tag, ".flush"},  32'(bus.flush_o), 32'd0);
    chk({tag, ".ready"},  32'(bus.ready_o), 32'd1);
  endtask

  // One accepted instruction from an idle state; checks br_signed in the issue cycle
  task automatic issue(input string tag, input logic br, input logic jal, input logic jalr,
                       input logic [2:0] f3, input logic less, input logic eq,
                       input logic exp_signed, input logic exp_taken);
    drive(1'b1, br, jal, jalr, f3, less, eq);
    #1;
    chk({tag, ".br_signed"}, 32'(bus.br_signed_o), 32'(exp_signed));
    chk({tag, ".ready_in"},  32'(bus.ready_o), 32'd1);
    tick();
    idle_in();
    if (exp_taken) expect_redirect(tag);
    else expect_none(tag);
  endtask

  // 10 legal branches, 4 taken: funct3, less, equal, signed, taken
  logic [2:0] t_f3   [10] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b100,
                              3'b100, 3'b101, 3'b110, 3'b110, 3'b111};
  logic       t_less [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic       t_eq   [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic       t_sgn  [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic       t_tk   [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    int fcnt;
    idle_in();
    tick();
    tick();
    chk("rst.ready",   32'(bus.ready_o),   32'd0);
    chk("rst.flush",   32'(bus.flush_o),   32'd0);
    chk("rst.pc_sel",  32'(bus.pc_sel_o),  32'd0);
    chk("rst.illegal", 32'(bus.illegal_o), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst.ready_rel", 32'(bus.ready_o), 32'd1);
    chk("rst.br_cnt",    bus.br_cnt_o,     32'd0);
    chk("rst.taken_cnt", bus.taken_cnt_o,  32'd0);
    tick();

    issue("beq_eq",    1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1);
    issue("bltu_lt",   1'b1, 1'b0, 1'b0, 3'b110, 1'b1, 1'b0, 1'b0, 1'b1);
    issue("blt_ge",    1'b1, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0);
    issue("bge_ge",    1'b1, 1'b0, 1'b0, 3'b101, 1'b0, 1'b0, 1'b1, 1'b1);
    issue("bgeu_ge",   1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1);
    issue("jalr",      1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
    issue("noflag",    1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("noflag.illegal", 32'(bus.illegal_o), 32'd0);

    // Reserved funct3: single illegal pulse, no redirect
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 1'b1);
    tick();
    idle_in();
    chk("ill.pulse",  32'(bus.illegal_o), 32'd1);
    chk("ill.pc_sel", 32'(bus.pc_sel_o),  32'd0);
    chk("ill.flush",  32'(bus.flush_o),   32'd0);
    tick();
    chk("ill.clear",  32'(bus.illegal_o), 32'd0);

    // JAL outranks a branch carrying reserved funct3
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b011, 1'b0, 1'b0);
    tick();
    idle_in();
    chk("jal_ill.illegal", 32'(bus.illegal_o), 32'd0);
    expect_redirect("jal_ill");
    chk("jal_ill.illegal2", 32'(bus.illegal_o), 32'd0);

    // JAL, then a second instruction held valid through the flush
    drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1);
    expect_redirect("held.first");
    tick();
    idle_in();
    expect_redirect("held.second");

    // FLUSH_CYCLES=3 instance: flush high exactly three cycles
    repeat (4) tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
    tick();
    idle_in();
    fcnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus3.flush_o) fcnt++;
      tick();
    end
    chk("fc3.flush_len", 32'(fcnt), 32'd3);

    // Asynchronous reset in the middle of a flush
    drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
    tick();
    idle_in();
    chk("arst.flush_before", 32'(bus.flush_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst.flush",  32'(bus.flush_o),  32'd0);
    chk("arst.pc_sel", 32'(bus.pc_sel_o), 32'd0);
    chk("arst.ready",  32'(bus.ready_o),  32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("arst.ready_rel", 32'(bus.ready_o), 32'd1);
    chk("arst.flush_rel", 32'(bus.flush_o), 32'd0);
    chk("arst.br_cnt",    bus.br_cnt_o,     32'd0);
    tick();

    // Statistics run: 10 branches (4 taken) plus 2 JALs
    for (int i = 0; i < 10; i++)
      issue($sformatf("tbl%0d", i), 1'b1, 1'b0, 1'b0, t_f3[i], t_less[i], t_eq[i],
            t_sgn[i], t_tk[i]);
    issue("st_jal0", 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
    issue("st_jal1", 1'b0, 1'b1, 1'b0, 3'b101, 1'b1, 1'b0, 1'b1, 1'b1);
`ifdef BR_STATS_EN
    chk("stats.br_cnt",    bus.br_cnt_o,    32'd10);
    chk("stats.taken_cnt", bus.taken_cnt_o, 32'd4);
`else
    chk("stats.br_cnt",    bus.br_cnt_o,    32'd0);
    chk("stats.taken_cnt", bus.taken_cnt_o, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
